// File: rtl/snake_tick_scheduler_if.sv
// Control pulses into and timing strobes/status out of the snake tick scheduler.
interface snake_tick_scheduler_if;
    logic       start;
    logic       pause_toggle;
    logic       game_over;
    logic       speed_up;
    logic       debounce_tick;
    logic       move_tick;
    logic [1:0] state;
    logic [2:0] level;

    modport master (
        output start, pause_toggle, game_over, speed_up,
        input  debounce_tick, move_tick, state, level
    );

    modport slave (
        input  start, pause_toggle, game_over, speed_up,
        output debounce_tick, move_tick, state, level
    );
endinterface

// File: rtl/snake_tick_scheduler.sv
// Game timing strobes as single-cycle clock enables: free-running debounce tick
// plus a move tick gated by a run/pause/halt FSM with a saturating speed level.
module snake_tick_scheduler #(
    parameter int          CNT_W     = 26,
    parameter int unsigned DEB_DIV   = 524288,
    parameter int unsigned MOVE_BASE = 33554432,
    parameter int unsigned MOVE_STEP = 4194304,
    parameter int unsigned MOVE_MIN  = 8388608,
    parameter int unsigned MAX_LEVEL = 7
) (
    input  logic                  clk_in,
    input  logic                  reset,
    snake_tick_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_DEB_LAST = CNT_W'(DEB_DIV - 1);
    localparam logic [CNT_W+2:0] LP_STEP     = (CNT_W+3)'(MOVE_STEP);
    localparam logic [CNT_W+2:0] LP_BASE     = (CNT_W+3)'(MOVE_BASE);
    localparam logic [CNT_W+2:0] LP_SPAN     = (CNT_W+3)'(MOVE_BASE - MOVE_MIN);
    localparam logic [CNT_W-1:0] LP_MIN      = CNT_W'(MOVE_MIN);
    localparam logic [2:0]       LP_MAX_LVL  = 3'(MAX_LEVEL);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_restart;
    logic [CNT_W-1:0] r_deb_cnt;
    logic             r_deb_tick;
    logic [CNT_W-1:0] r_move_cnt;
    logic             r_move_tick;
    logic [2:0]       r_level;
    logic [CNT_W+2:0] w_dec;
    logic [CNT_W+2:0] w_diff;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_period_m1;
    logic             w_wrap;
    logic             w_tick_nxt;
    logic             w_level_inc;

    // Clamp before subtracting so the period never underflows at high levels.
    assign w_dec       = {{CNT_W{1'b0}}, r_level} * LP_STEP;
    assign w_diff      = LP_BASE - w_dec;
    assign w_period    = (w_dec >= LP_SPAN) ? LP_MIN : CNT_W'(w_diff);
    assign w_period_m1 = w_period - CNT_W'(1);

    assign w_wrap      = (r_state == S_RUN) && (r_move_cnt >= w_period_m1);
    assign w_tick_nxt  = w_wrap && (w_state_nxt == S_RUN) && !w_restart;
    assign w_level_inc = bus.speed_up && ((r_state == S_RUN) || (r_state == S_PAUSE))
                         && !w_restart && (r_level < LP_MAX_LVL);

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_restart   = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.game_over) begin
                    w_state_nxt = S_HALT;
                end else if (bus.start) begin
                    w_restart   = 1'b1;
                end else if (bus.pause_toggle) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (bus.game_over) begin
                    w_state_nxt = S_HALT;
                end else if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_restart   = 1'b1;
                end else if (bus.pause_toggle) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_restart   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_deb_cnt  <= '0;
            r_deb_tick <= 1'b0;
        end else if (r_deb_cnt == LP_DEB_LAST) begin
            r_deb_cnt  <= '0;
            r_deb_tick <= 1'b1;
        end else begin
            r_deb_cnt  <= r_deb_cnt + CNT_W'(1);
            r_deb_tick <= 1'b0;
        end
    end

    // The counter still wraps when the tick is suppressed by a leaving transition.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_move_cnt  <= '0;
            r_move_tick <= 1'b0;
            r_level     <= '0;
        end else begin
            r_move_tick <= w_tick_nxt;
            if (w_restart) begin
                r_move_cnt <= '0;
                r_level    <= '0;
            end else begin
                if (r_state == S_RUN) begin
                    r_move_cnt <= w_wrap ? '0 : (r_move_cnt + CNT_W'(1));
                end
                if (w_level_inc) begin
                    r_level <= r_level + 3'd1;
                end
            end
        end
    end

    assign bus.debounce_tick = r_deb_tick;
    assign bus.move_tick     = r_move_tick;
    assign bus.state         = r_state;
    assign bus.level         = r_level;
endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Directed bench for snake_tick_scheduler with small periods (DEB_DIV=4, periods 16/12/8/6).
module tb_snake_tick_scheduler;
    logic clk_in;
    logic reset;
    int   n_checks;
    int   n_errors;

    snake_tick_scheduler_if bus();

    snake_tick_scheduler #(
        .CNT_W    (8),
        .DEB_DIV  (4),
        .MOVE_BASE(16),
        .MOVE_STEP(4),
        .MOVE_MIN (6),
        .MAX_LEVEL(7)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.pause_toggle = 1'b0;
        bus.game_over    = 1'b0;
        bus.speed_up     = 1'b0;
        step();
        step();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_mtick", 32'(bus.move_tick), 0);
        chk("rst_dtick", 32'(bus.debounce_tick), 0);

        // Debounce strobe: pulses after edges 4, 8, ... 20; nothing else moves.
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("deb_tick", 32'(bus.debounce_tick), 32'((c % 4) == 0));
            chk("deb_mtick", 32'(bus.move_tick), 0);
            chk("deb_state", 32'(bus.state), 0);
        end

        // Start and cadence at level 0 (period 16).
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_state", 32'(bus.state), 1);
        chk("start_level", 32'(bus.level), 0);
        for (int c = 1; c <= 48; c++) begin
            step();
            chk("cadence_tick", 32'(bus.move_tick), 32'((c % 16) == 0));
        end

        // Pause at edge 10, resume at edge 30: tick moves from 16 to 36.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            bus.pause_toggle = (c == 10) || (c == 30);
            step();
            bus.pause_toggle = 1'b0;
            chk("pause_tick", 32'(bus.move_tick), 32'(c == 36));
            if (c == 10) chk("pause_state", 32'(bus.state), 2);
            if (c == 30) chk("resume_state", 32'(bus.state), 1);
        end

        // Mid-count shrink: level 2 reached with counter at 10, wrap on next edge.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            bus.speed_up = (c == 9) || (c == 10);
            step();
            bus.speed_up = 1'b0;
            chk("shrink_tick", 32'(bus.move_tick), 32'((c == 11) || (c == 19) || (c == 27)));
            if (c == 10) chk("shrink_level", 32'(bus.level), 2);
        end

        // Speed saturation: nine requests, level caps at 7, period clamps at 6.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("sat_restart_level", 32'(bus.level), 0);
        for (int k = 1; k <= 9; k++) begin
            bus.speed_up = 1'b1;
            step();
            chk("sat_level", 32'(bus.level), (k < 7) ? k : 7);
            chk("sat_tick", 32'(bus.move_tick), 32'(k == 6));
        end
        bus.speed_up = 1'b0;
        for (int c = 10; c <= 24; c++) begin
            step();
            chk("sat_cadence", 32'(bus.move_tick), 32'((c == 12) || (c == 18) || (c == 24)));
        end

        // Game over coincident with a wrap (period 6): no tick, HALT, level held.
        for (int c = 1; c <= 6; c++) begin
            bus.game_over = (c == 6);
            step();
            bus.game_over = 1'b0;
            chk("go_tick", 32'(bus.move_tick), 0);
        end
        chk("go_state", 32'(bus.state), 3);
        chk("go_level", 32'(bus.level), 7);
        for (int c = 1; c <= 8; c++) begin
            bus.pause_toggle = 1'b1;
            bus.speed_up     = 1'b1;
            step();
        end
        bus.pause_toggle = 1'b0;
        bus.speed_up     = 1'b0;
        chk("halt_state", 32'(bus.state), 3);
        chk("halt_level", 32'(bus.level), 7);
        chk("halt_tick", 32'(bus.move_tick), 0);

        // Restart from HALT: first tick 16 edges later.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("rs_state", 32'(bus.state), 1);
        chk("rs_level", 32'(bus.level), 0);
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("rs_tick", 32'(bus.move_tick), 32'(c == 16));
        end

        // Reset on the edge that would wrap at level 1 (period 12).
        bus.speed_up = 1'b1;
        step();
        bus.speed_up = 1'b0;
        chk("pre_rst_level", 32'(bus.level), 1);
        for (int c = 1; c <= 10; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_tick", 32'(bus.move_tick), 0);
        chk("mid_rst_state", 32'(bus.state), 0);
        chk("mid_rst_level", 32'(bus.level), 0);
        chk("mid_rst_dtick", 32'(bus.debounce_tick), 0);

        // IDLE ignores pause and game over.
        bus.pause_toggle = 1'b1;
        bus.game_over    = 1'b1;
        step();
        bus.pause_toggle = 1'b0;
        bus.game_over    = 1'b0;
        step();
        chk("idle_ignore_state", 32'(bus.state), 0);
        chk("idle_ignore_tick", 32'(bus.move_tick), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/snake_tick_scheduler.md
# snake_tick_scheduler

Generates the game's timing strobes as single-cycle clock enables on the main clock rather than divided clocks. A free-running debounce strobe serves the button debouncers. A gated move strobe paces snake movement and is sequenced by a run/pause/halt state machine with a saturating speed level. Sits between the top-level clock/reset and the debouncer, snake-movement and scoring logic.

## Interface
- `CNT_W`, 26: width of the internal period counters.
- `DEB_DIV`, 524288: debounce strobe period in clock cycles; minimum 2.
- `MOVE_BASE`, 33554432: move period at level 0, in cycles.
- `MOVE_STEP`, 4194304: period reduction per level.
- `MOVE_MIN`, 8388608: floor on the move period; minimum 2.
- `MAX_LEVEL`, 7: highest speed level; maximum 7.
- `clk_in`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse that starts or restarts a game.
- `pause_toggle`  in  1: single-cycle pulse that toggles between RUN and PAUSE.
- `game_over`  in  1: single-cycle pulse from collision logic.
- `speed_up`  in  1: single-cycle pulse that requests the next speed level.
- `debounce_tick`  out  1: one-cycle enable every `DEB_DIV` cycles.
- `move_tick`  out  1: one-cycle enable pacing snake moves.
- `state`  out  2: current state; 0=IDLE, 1=RUN, 2=PAUSE, 3=HALT.
- `level`  out  3: current speed level.

## Operation
- **Reset values:** `state`=IDLE, `level`=0, both counters=0, `debounce_tick`=0, `move_tick`=0.
- **Debounce counter:**
  - Counts 0 to `DEB_DIV`-1 and wraps.
  - `debounce_tick` is registered and asserted for the one cycle following the wrap edge.
  - Runs in every state; only `reset` clears it.
- **Move period:** `period` = max(`MOVE_BASE` − `level`·`MOVE_STEP`, `MOVE_MIN`).
  - Computed combinationally at `CNT_W` bits.
  - The subtraction must not underflow; clamp to `MOVE_MIN` whenever `level`·`MOVE_STEP` ≥ `MOVE_BASE` − `MOVE_MIN`.
- **Move counter:**
  - Increments only in RUN.
  - When counter ≥ `period`−1, it returns to 0 and `move_tick` is registered high for the next cycle.
  - The ≥ compare makes a mid-count period shrink take effect on the next cycle without a missed wrap.
  - Holds its value in PAUSE.
  - Cleared on every entry to RUN from IDLE or HALT.
- **FSM transitions** (evaluated each edge; priority `reset` > `game_over` > `start` > `pause_toggle`):
  - IDLE: `start` → RUN, with `level`←0 and move counter←0. `game_over` and `pause_toggle` are ignored.
  - RUN: `game_over` → HALT. `start` → RUN restart (`level`←0, counter←0). `pause_toggle` → PAUSE.
  - PAUSE: `game_over` → HALT. `start` → RUN restart. `pause_toggle` → RUN, with the counter resuming from its held value.
  - HALT: `start` → RUN restart. All other inputs are ignored. `level` holds so the final speed stays visible.
- **Speed level:**
  - `speed_up` in RUN or PAUSE increments `level`, saturating at `MAX_LEVEL`.
  - `speed_up` is ignored in IDLE and HALT.
  - `speed_up` in the same cycle as a restarting `start` is dropped; `level` becomes 0.
- **Move strobe gating:**
  - `move_tick` is never asserted in the cycle after a transition out of RUN.
  - A wrap coincident with `game_over` or `pause_toggle` suppresses the tick, and the counter still wraps.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `start` sampled at edge E:
  - `state`=RUN from E+1.
  - First `move_tick` is high in the cycle after edge E+`period`.
  - Subsequent ticks follow every `period` cycles while the level is unchanged.
- `debounce_tick`: first pulse in the cycle after edge `DEB_DIV`, counting from the first edge with `reset` low. Pulses then repeat every `DEB_DIV` cycles.
- `level` updates one edge after `speed_up`. The new `period` applies to the compare from that edge onward.
- PAUSE freezes the move phase exactly: total RUN cycles between consecutive ticks equals `period`, excluding paused cycles.
- `reset` mid-game: the next edge forces all reset values. No tick is emitted in the cycle after that edge.

## Test plan
Parameters for all scenarios: `DEB_DIV`=4, `MOVE_BASE`=16, `MOVE_STEP`=4, `MOVE_MIN`=6, `MAX_LEVEL`=7.
- **Debounce strobe:** release reset, hold it low for 20 cycles → `debounce_tick` high at cycles 4, 8, 12, 16, 20 only; `move_tick` stays 0 and `state`=0.
- **Start and move cadence:** `start` at cycle 0 → `state`=1 at cycle 1; `move_tick` high at cycles 16, 32, 48.
- **Pause and resume:** `start`, then `pause_toggle` at cycle 10, then `pause_toggle` again at cycle 30 → no ticks during 11–30; next tick at cycle 36.
- **Speed saturation:** `speed_up` ×9 while in RUN → `level` 1, 2, …, 7 and stays at 7; period sequence 12, 8, 6, 6 (clamped, no underflow).
- **Mid-count period shrink:** at level 0 with counter at 10, pulse `speed_up` twice (period 8) → tick on the next cycle after the counter reaches ≥7, and the counter wraps to 0.
- **Game over and restart:** `game_over` coincident with a wrap → no tick, `state`=3, `level` held; `start` → `state`=1, `level`=0, first tick 16 cycles later; `reset` mid-RUN → all outputs 0 next cycle.
